// File: rtl/match_referee.sv
// Match sequencing for the pong game: counts goals from the ball controller's
// toggle outputs, paces kickoffs after each goal and declares the winner.
module match_referee #(
   parameter int WIN_SCORE     = 5,
   parameter int SCORE_WIDTH   = 4,
   parameter int RESTART_DELAY = 50_000_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_btn,
   input  logic                   blue_score_up,
   input  logic                   red_score_up,
   output logic                   game_initiated,
   output logic                   game_over,
   output logic [SCORE_WIDTH-1:0] blue_score,
   output logic [SCORE_WIDTH-1:0] red_score,
   output logic [1:0]             winner,
   output logic                   goal_flash,
   output logic [1:0]             state_dbg
);

   localparam int CNT_W = $clog2(RESTART_DELAY + 1);
   localparam logic [SCORE_WIDTH-1:0] WIN    = SCORE_WIDTH'(WIN_SCORE);
   localparam logic [SCORE_WIDTH-1:0] ONE    = SCORE_WIDTH'(1);
   localparam logic [CNT_W-1:0]       RELOAD = CNT_W'(RESTART_DELAY - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAYING   = 2'd1,
      PAUSE     = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SCORE_WIDTH-1:0] blue_q, blue_d, red_q, red_d;
   logic [1:0]             winner_q, winner_d;
   logic                   over_q, over_d;
   logic                   flash_q, flash_d;
   logic                   init_q, init_d;
   logic                   start_prev, blue_prev, red_prev;

   logic                   start, blue_goal, red_goal;
   logic [SCORE_WIDTH-1:0] blue_new, red_new;

   assign start     = start_btn & ~start_prev;
   assign blue_goal = blue_score_up ^ blue_prev;
   assign red_goal  = red_score_up ^ red_prev;

   // Saturating increments; a score below WIN never wraps.
   assign blue_new = !blue_goal ? blue_q : (blue_q >= WIN) ? WIN : blue_q + ONE;
   assign red_new  = !red_goal  ? red_q  : (red_q  >= WIN) ? WIN : red_q  + ONE;

   // start_prev resets high so a button held through reset is not a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         blue_q     <= '0;
         red_q      <= '0;
         winner_q   <= 2'b00;
         over_q     <= 1'b0;
         flash_q    <= 1'b0;
         init_q     <= 1'b0;
         start_prev <= 1'b1;
         blue_prev  <= 1'b0;
         red_prev   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         blue_q     <= blue_d;
         red_q      <= red_d;
         winner_q   <= winner_d;
         over_q     <= over_d;
         flash_q    <= flash_d;
         init_q     <= init_d;
         start_prev <= start_btn;
         blue_prev  <= blue_score_up;
         red_prev   <= red_score_up;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      blue_d   = blue_q;
      red_d    = red_q;
      winner_d = winner_q;
      over_d   = over_q;
      flash_d  = flash_q;
      init_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               init_d  = 1'b1;
               state_d = PLAYING;
            end
         end
         PLAYING: begin
            if (blue_goal || red_goal) begin
               blue_d = blue_new;
               red_d  = red_new;
               if (blue_new == WIN || red_new == WIN) begin
                  state_d  = GAME_OVER;
                  over_d   = 1'b1;
                  winner_d = {red_new == WIN, blue_new == WIN};
               end else begin
                  state_d = PAUSE;
                  cnt_d   = RELOAD;
                  flash_d = 1'b1;
               end
            end
         end
         PAUSE: begin
            if (cnt_q == '0) begin
               init_d  = 1'b1;
               flash_d = 1'b0;
               state_d = PLAYING;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAME_OVER: begin
            // Relaunch and game_over drop land on the same edge.
            if (start) begin
               blue_d   = '0;
               red_d    = '0;
               winner_d = 2'b00;
               over_d   = 1'b0;
               init_d   = 1'b1;
               state_d  = PLAYING;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      game_initiated = init_q;
      game_over      = over_q;
      blue_score     = blue_q;
      red_score      = red_q;
      winner         = winner_q;
      goal_flash     = flash_q;
      state_dbg      = state_q;
   end

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee (WIN_SCORE=3, RESTART_DELAY=4): a cycle
// table of inputs/expected outputs plus hand sequences for reset behaviour.
module tb_match_referee;

   localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3;

   logic       clk, rst_n, start_btn, blue_score_up, red_score_up;
   logic       game_initiated, game_over, goal_flash;
   logic [3:0] blue_score, red_score;
   logic [1:0] winner, state_dbg;

   typedef struct packed {
      logic       init;
      logic       over;
      logic [3:0] bs;
      logic [3:0] rs;
      logic [1:0] win;
      logic       fl;
      logic [1:0] st;
   } out_t;

   typedef struct {
      logic s;
      logic b;
      logic r;
      out_t exp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   fails  = 0;

   match_referee #(.WIN_SCORE(3), .SCORE_WIDTH(4), .RESTART_DELAY(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn),
      .blue_score_up(blue_score_up), .red_score_up(red_score_up),
      .game_initiated(game_initiated), .game_over(game_over),
      .blue_score(blue_score), .red_score(red_score), .winner(winner),
      .goal_flash(goal_flash), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t actual();
      out_t a;
      a.init = game_initiated;
      a.over = game_over;
      a.bs   = blue_score;
      a.rs   = red_score;
      a.win  = winner;
      a.fl   = goal_flash;
      a.st   = state_dbg;
      return a;
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t a;
      a = actual();
      checks++;
      if (a !== exp) begin
         fails++;
         $display("FAIL %s: got init=%b over=%b blue=%0d red=%0d win=%b flash=%b st=%0d, want init=%b over=%b blue=%0d red=%0d win=%b flash=%b st=%0d",
                  name, a.init, a.over, a.bs, a.rs, a.win, a.fl, a.st,
                  exp.init, exp.over, exp.bs, exp.rs, exp.win, exp.fl, exp.st);
      end
   endtask

   task automatic add(input logic s, input logic b, input logic r,
                      input logic init, input logic over, input int bs, input int rs,
                      input logic [1:0] win, input logic fl, input logic [1:0] st);
      vec_t v;
      v.s = s; v.b = b; v.r = r;
      v.exp.init = init;
      v.exp.over = over;
      v.exp.bs   = 4'(bs);
      v.exp.rs   = 4'(rs);
      v.exp.win  = win;
      v.exp.fl   = fl;
      v.exp.st   = st;
      vecs.push_back(v);
   endtask

   out_t zero_out;

   initial begin
      zero_out = '0;
      //  s  b  r   init over bs rs win   fl  state
      add(1, 0, 0,  0, 0, 0, 0, 2'b00, 0, S_IDLE);   // held through reset
      add(0, 0, 0,  0, 0, 0, 0, 2'b00, 0, S_IDLE);
      add(1, 0, 0,  1, 0, 0, 0, 2'b00, 0, S_PLAY);   // fresh press
      add(1, 0, 0,  0, 0, 0, 0, 2'b00, 0, S_PLAY);
      add(0, 0, 0,  0, 0, 0, 0, 2'b00, 0, S_PLAY);
      add(0, 1, 0,  0, 0, 1, 0, 2'b00, 1, S_PAUSE);  // blue goal 1
      add(0, 1, 1,  0, 0, 1, 0, 2'b00, 1, S_PAUSE);  // red toggles ignored
      add(0, 1, 0,  0, 0, 1, 0, 2'b00, 1, S_PAUSE);
      add(0, 1, 0,  0, 0, 1, 0, 2'b00, 1, S_PAUSE);
      add(0, 1, 0,  1, 0, 1, 0, 2'b00, 0, S_PLAY);   // relaunch 4 after score
      add(0, 1, 0,  0, 0, 1, 0, 2'b00, 0, S_PLAY);   // no late red goal
      add(0, 0, 0,  0, 0, 2, 0, 2'b00, 1, S_PAUSE);  // blue goal 2
      add(0, 0, 0,  0, 0, 2, 0, 2'b00, 1, S_PAUSE);
      add(0, 0, 0,  0, 0, 2, 0, 2'b00, 1, S_PAUSE);
      add(0, 0, 0,  0, 0, 2, 0, 2'b00, 1, S_PAUSE);
      add(0, 0, 0,  1, 0, 2, 0, 2'b00, 0, S_PLAY);
      add(0, 1, 0,  0, 1, 3, 0, 2'b01, 0, S_OVER);   // blue wins
      add(0, 0, 1,  0, 1, 3, 0, 2'b01, 0, S_OVER);   // frozen
      add(0, 0, 1,  0, 1, 3, 0, 2'b01, 0, S_OVER);
      add(1, 0, 1,  1, 0, 0, 0, 2'b00, 0, S_PLAY);   // restart
      add(0, 0, 1,  0, 0, 0, 0, 2'b00, 0, S_PLAY);
      add(0, 1, 0,  0, 0, 1, 1, 2'b00, 1, S_PAUSE);  // both score
      add(0, 1, 0,  0, 0, 1, 1, 2'b00, 1, S_PAUSE);
      add(0, 1, 0,  0, 0, 1, 1, 2'b00, 1, S_PAUSE);
      add(0, 1, 0,  0, 0, 1, 1, 2'b00, 1, S_PAUSE);
      add(0, 1, 0,  1, 0, 1, 1, 2'b00, 0, S_PLAY);
      add(0, 0, 1,  0, 0, 2, 2, 2'b00, 1, S_PAUSE);
      add(0, 0, 1,  0, 0, 2, 2, 2'b00, 1, S_PAUSE);
      add(0, 0, 1,  0, 0, 2, 2, 2'b00, 1, S_PAUSE);
      add(0, 0, 1,  0, 0, 2, 2, 2'b00, 1, S_PAUSE);
      add(0, 0, 1,  1, 0, 2, 2, 2'b00, 0, S_PLAY);
      add(0, 1, 0,  0, 1, 3, 3, 2'b11, 0, S_OVER);   // draw
      add(0, 0, 1,  0, 1, 3, 3, 2'b11, 0, S_OVER);
      add(1, 0, 1,  1, 0, 0, 0, 2'b00, 0, S_PLAY);
      add(0, 0, 0,  0, 0, 0, 1, 2'b00, 1, S_PAUSE);  // red goal 1
      add(0, 0, 0,  0, 0, 0, 1, 2'b00, 1, S_PAUSE);
      add(0, 0, 0,  0, 0, 0, 1, 2'b00, 1, S_PAUSE);
      add(0, 0, 0,  0, 0, 0, 1, 2'b00, 1, S_PAUSE);
      add(0, 0, 0,  1, 0, 0, 1, 2'b00, 0, S_PLAY);
      add(0, 0, 1,  0, 0, 0, 2, 2'b00, 1, S_PAUSE);
      add(0, 0, 1,  0, 0, 0, 2, 2'b00, 1, S_PAUSE);
      add(0, 0, 1,  0, 0, 0, 2, 2'b00, 1, S_PAUSE);
      add(0, 0, 1,  0, 0, 0, 2, 2'b00, 1, S_PAUSE);
      add(0, 0, 1,  1, 0, 0, 2, 2'b00, 0, S_PLAY);
      add(0, 0, 0,  0, 1, 0, 3, 2'b10, 0, S_OVER);   // red wins
      add(1, 0, 0,  1, 0, 0, 0, 2'b00, 0, S_PLAY);
      add(0, 1, 0,  0, 0, 1, 0, 2'b00, 1, S_PAUSE);
      add(0, 1, 0,  0, 0, 1, 0, 2'b00, 1, S_PAUSE);

      // Reset asserted with the start button held.
      rst_n         = 1'b0;
      start_btn     = 1'b1;
      blue_score_up = 1'b0;
      red_score_up  = 1'b0;
      #1;
      check("reset_state", zero_out);
      @(negedge clk);
      @(negedge clk);
      check("reset_held_over_edges", zero_out);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         start_btn     = vecs[i].s;
         blue_score_up = vecs[i].b;
         red_score_up  = vecs[i].r;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Mid-PAUSE asynchronous reset, observed before the next clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_mid_pause", zero_out);
      @(negedge clk);
      start_btn = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      check("idle_after_reset", zero_out);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
